// File: rtl/bcd_display_scan_if.sv
// Shared 7-segment encoding and the load/display bus of the multiplexed BCD display driver.
// Segment patterns are gfedcba, active-high.
package definitions_pkg;
  typedef enum logic [6:0] {
    OFF   = 7'h00,
    ZERO  = 7'h3F,
    ONE   = 7'h06,
    TWO   = 7'h5B,
    TREE  = 7'h4F,
    FOUR  = 7'h66,
    FIVE  = 7'h6D,
    SIX   = 7'h7D,
    SEVEN = 7'h07,
    EIGHT = 7'h7F,
    NINE  = 7'h6F,
    SIGN  = 7'h40
  } segment_e;
endpackage

interface bcd_display_scan_if #(
  parameter int DIGITS = 4
);
  import definitions_pkg::*;

  logic [4*DIGITS-1:0] i_bcd;
  logic                i_sign;
  logic                i_rdy;
  logic                i_enable;
  logic [DIGITS-1:0]   o_digit_sel;
  segment_e            o_segments;
  logic                o_valid;

  modport master (
    output i_bcd, i_sign, i_rdy, i_enable,
    input  o_digit_sel, o_segments, o_valid
  );

  modport slave (
    input  i_bcd, i_sign, i_rdy, i_enable,
    output o_digit_sel, o_segments, o_valid
  );
endinterface

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment driver: captures a signed BCD value and scans it MSD first,
// with leading-zero blanking and a dark guard interval at the start of every digit slot.
//
// state  | meaning
// S_IDLE | display dark, slot counter and digit index held at zero
// S_SCAN | slot counter running, one digit lit per slot after the guard cycles
module bcd_display_scan
  import definitions_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD         = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic            clk,
  input  logic            rst,
  bcd_display_scan_if.slave bus
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic {S_IDLE, S_SCAN} state_e;

  state_e              state, state_nx;
  logic [CNT_W-1:0]    slot_cnt, cnt_nx;
  logic [IDX_W-1:0]    dig_idx, idx_nx;
  logic [4*DIGITS-1:0] shadow_bcd;
  logic                shadow_sign;
  logic                valid;
  logic [DIGITS-1:0]   digit_sel, sel_nx;
  segment_e            segments, seg_nx;
  segment_e            dig_seg [DIGITS];
  logic                run;

  function automatic segment_e decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return ZERO;
      4'd1:    return ONE;
      4'd2:    return TWO;
      4'd3:    return TREE;
      4'd4:    return FOUR;
      4'd5:    return FIVE;
      4'd6:    return SIX;
      4'd7:    return SEVEN;
      4'd8:    return EIGHT;
      4'd9:    return NINE;
      4'd10:   return SIGN;
      default: return OFF;
    endcase
  endfunction

  // Walk from the top digit down; lead_zero stays set only while every digit seen so far is 0.
  // A sign in the top position is skipped so blanking starts at the next digit.
  always_comb begin
    logic       lead_zero;
    logic [3:0] nib;
    lead_zero = 1'b1;
    nib       = 4'd0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib        = shadow_bcd[4*k +: 4];
      dig_seg[k] = decode(nib);
      if (shadow_sign && k == DIGITS - 1) begin
        dig_seg[k] = SIGN;
      end else begin
        lead_zero = lead_zero & (nib == 4'd0);
        if (BLANK_LEADING != 0 && k != 0 && lead_zero) dig_seg[k] = OFF;
      end
    end
  end

  assign run = bus.i_enable & valid;

  always_comb begin
    state_nx = state;
    cnt_nx   = slot_cnt;
    idx_nx   = dig_idx;
    sel_nx   = '0;
    seg_nx   = OFF;
    if (!run) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_nx = S_SCAN;
          cnt_nx   = '0;
          idx_nx   = IDX_W'(DIGITS - 1);
        end
        S_SCAN: begin
          if (slot_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_nx = '0;
            idx_nx = (dig_idx == '0) ? IDX_W'(DIGITS - 1) : dig_idx - IDX_W'(1);
          end else begin
            cnt_nx = slot_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
    // Select and segments come from the same next count/index so they never disagree.
    if (state_nx == S_SCAN && cnt_nx >= CNT_W'(GUARD)) begin
      sel_nx = DIGITS'(1) << idx_nx;
      seg_nx = dig_seg[idx_nx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      slot_cnt    <= '0;
      dig_idx     <= '0;
      shadow_bcd  <= '0;
      shadow_sign <= 1'b0;
      valid       <= 1'b0;
      digit_sel   <= '0;
      segments    <= OFF;
    end else begin
      if (bus.i_rdy) begin
        shadow_bcd  <= bus.i_bcd;
        shadow_sign <= bus.i_sign;
        valid       <= 1'b1;
      end
      state     <= state_nx;
      slot_cnt  <= cnt_nx;
      dig_idx   <= idx_nx;
      digit_sel <= sel_nx;
      segments  <= seg_nx;
    end
  end

  assign bus.o_digit_sel = digit_sel;
  assign bus.o_segments  = segments;
  assign bus.o_valid     = valid;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench: two lock-stepped drivers (blanking on / off) fed the same stimulus;
// expected lit slots are queued by the stimulus and retired by an independent monitor.
module tb_bcd_display_scan;
  import definitions_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd = '0;
  logic        sign = 1'b0;
  logic        rdy = 1'b0;
  logic        enable = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] sel;
    segment_e   s0;
    segment_e   s1;
  } exp_t;

  exp_t sb[$];
  int   lit_run   = 0;
  bit   exp_guard = 1'b0;

  bcd_display_scan_if #(.DIGITS(4)) bus0 ();
  bcd_display_scan_if #(.DIGITS(4)) bus1 ();

  assign bus0.i_bcd = bcd;  assign bus0.i_sign = sign;
  assign bus0.i_rdy = rdy;  assign bus0.i_enable = enable;
  assign bus1.i_bcd = bcd;  assign bus1.i_sign = sign;
  assign bus1.i_rdy = rdy;  assign bus1.i_enable = enable;

  bcd_display_scan #(.DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .BLANK_LEADING(1)) u0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  bcd_display_scan #(.DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .BLANK_LEADING(0)) u1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_dark(input string name, input logic exp_valid);
    chk({name, "_sel0"}, 32'(bus0.o_digit_sel), 32'd0);
    chk({name, "_seg0"}, 32'(bus0.o_segments), 32'(OFF));
    chk({name, "_sel1"}, 32'(bus1.o_digit_sel), 32'd0);
    chk({name, "_seg1"}, 32'(bus1.o_segments), 32'(OFF));
    chk({name, "_valid"}, 32'(bus0.o_valid), 32'(exp_valid));
  endtask

  // Monitor: each lit slot must last three cycles, match the queue head, then be followed by a guard cycle.
  always @(negedge clk) begin
    if (exp_guard) begin
      exp_guard = 1'b0;
      chk("guard_sel", 32'(bus0.o_digit_sel | bus1.o_digit_sel), 32'd0);
      chk("guard_seg", 32'(bus0.o_segments | bus1.o_segments), 32'(OFF));
    end else if (bus0.o_digit_sel != 4'd0 && sb.size() != 0) begin
      chk("slot_sel_bl1", 32'(bus0.o_digit_sel), 32'(sb[0].sel));
      chk("slot_sel_bl0", 32'(bus1.o_digit_sel), 32'(sb[0].sel));
      chk("slot_seg_bl1", 32'(bus0.o_segments), 32'(sb[0].s0));
      chk("slot_seg_bl0", 32'(bus1.o_segments), 32'(sb[0].s1));
      lit_run++;
      if (lit_run == 3) begin
        void'(sb.pop_front());
        lit_run   = 0;
        exp_guard = 1'b1;
      end
    end else if (bus0.o_digit_sel == 4'd0 && lit_run != 0) begin
      chk("slot_len", 32'(lit_run), 32'd3);
      lit_run = 0;
    end
  end

  task automatic push_exp(input logic [27:0] p0, input logic [27:0] p1);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.sel = 4'b1000 >> i;
      e.s0  = segment_e'(p0[27-7*i -: 7]);
      e.s1  = segment_e'(p1[27-7*i -: 7]);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run_vec(input logic [15:0] v, input logic s, input logic [27:0] p0,
                         input logic [27:0] p1, input int reps);
    @(posedge clk); #1;
    enable = 1'b0; bcd = v; sign = s; rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    for (int r = 0; r < reps; r++) push_exp(p0, p1);
    enable = 1'b1;
    drain();
    #1 enable = 1'b0;
    chk("valid_after_load", 32'(bus0.o_valid & bus1.o_valid), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_dark("idle", 1'b0);
    end

    run_vec(16'h1234, 1'b0, {ONE, TWO, TREE, FOUR}, {ONE, TWO, TREE, FOUR}, 2);
    run_vec(16'h0007, 1'b0, {OFF, OFF, OFF, SEVEN}, {ZERO, ZERO, ZERO, SEVEN}, 1);
    run_vec(16'h0000, 1'b0, {OFF, OFF, OFF, ZERO}, {ZERO, ZERO, ZERO, ZERO}, 1);
    run_vec(16'h0042, 1'b1, {SIGN, OFF, FOUR, TWO}, {SIGN, ZERO, FOUR, TWO}, 1);
    run_vec(16'h9ABF, 1'b0, {NINE, SIGN, OFF, OFF}, {NINE, SIGN, OFF, OFF}, 1);
    run_vec(16'h0100, 1'b0, {OFF, ONE, ZERO, ZERO}, {ZERO, ONE, ZERO, ZERO}, 1);
    run_vec(16'h5003, 1'b1, {SIGN, OFF, OFF, TREE}, {SIGN, ZERO, ZERO, TREE}, 1);
    run_vec(16'h0000, 1'b1, {SIGN, OFF, OFF, ZERO}, {SIGN, ZERO, ZERO, ZERO}, 1);

    // Enable drop mid-scan, then restart from the top digit with the retained value.
    run_vec(16'h1234, 1'b0, {ONE, TWO, TREE, FOUR}, {ONE, TWO, TREE, FOUR}, 1);
    @(posedge clk); #1 enable = 1'b1;
    repeat (6) @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    chk("pre_disable_sel", 32'(bus0.o_digit_sel), 32'b0100);
    chk("pre_disable_seg", 32'(bus0.o_segments), 32'(TWO));
    @(negedge clk);
    chk_dark("disabled", 1'b1);
    @(posedge clk); #1;
    push_exp({ONE, TWO, TREE, FOUR}, {ONE, TWO, TREE, FOUR});
    enable = 1'b1;
    @(negedge clk);
    chk_dark("reenable_guard", 1'b1);
    drain();

    // Reset mid-slot clears everything; display stays dark until a reload.
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("pre_reset_sel", 32'(bus0.o_digit_sel), 32'b1000);
    @(negedge clk);
    chk_dark("reset_mid", 1'b0);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk_dark("post_reset", 1'b0);
    end

    // Reset coinciding with a load: nothing captured.
    @(posedge clk); #1 rst = 1'b1; rdy = 1'b1; bcd = 16'h1234; sign = 1'b0;
    @(posedge clk); #1 rst = 1'b0; rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_dark("rst_vs_rdy", 1'b0);
    end

    run_vec(16'h0042, 1'b1, {SIGN, OFF, FOUR, TWO}, {SIGN, ZERO, FOUR, TWO}, 1);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Parametrised, time-multiplexed driver for a DIGITS-wide 7-segment display bank.
- Captures a packed multi-digit BCD value plus sign on a ready strobe and scans one digit per refresh slot.
- Suppresses leading zeros and inserts an anti-ghosting guard interval between digits.
- Sits between the arithmetic/result datapath and the board display pins. Reuses the segment_e encoding from definitions_pkg.

Parameters:
- DIGITS, 4, number of display digits; must be ≥ 2.
- REFRESH_DIV, 50000, clock cycles each digit slot lasts, including the guard interval; must be ≥ 2.
- GUARD, 1, cycles at the start of each slot with all digit selects inactive; must be < REFRESH_DIV.
- BLANK_LEADING, 1, 1 = leading-zero suppression on; 0 = all digits shown.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- i_bcd  in  4*DIGITS  packed BCD value; nibble k is digit k, and digit 0 is least significant.
- i_sign  in  1  1 = value is negative.
- i_rdy  in  1  load strobe; captures i_bcd/i_sign on the clock edge where it is high.
- i_enable  in  1  0 = display dark and scan held in its reset state.
- o_digit_sel  out  DIGITS  one-hot digit enable, active-high; all zeros while idle or in a guard cycle.
- o_segments  out  segment_e  segment pattern for the currently selected digit.
- o_valid  out  1  1 once at least one value has been captured since reset.

Behaviour:
- Reset: all of the following are cleared when rst is high at a clock edge.
  - Shadow BCD register → all digits 0. Sign → 0. o_valid → 0.
  - Slot counter → 0. Digit index → 0.
  - o_digit_sel → 0. o_segments → OFF.
- Capture:
  - i_rdy high at edge N loads the shadow register and sets o_valid.
  - Capture works regardless of i_enable.
  - The new value reaches the outputs at edge N+1 at the earliest, i.e. one registered stage after the shadow register.
  - i_rdy held high reloads every cycle.
- Scan:
  - The slot counter runs 0..REFRESH_DIV-1 while i_enable=1 and o_valid=1.
  - At terminal count the counter wraps to 0 and the digit index advances DIGITS-1 → ... → 1 → 0 → DIGITS-1, i.e. most significant digit first, wrapping at 0.
  - The first slot after enable shows digit DIGITS-1.
- Guard:
  - For slot counts 0..GUARD-1, o_digit_sel = 0 and o_segments = OFF.
  - For the remaining counts, o_digit_sel has bit [index] set and o_segments shows the decode for that digit.
- Outputs: o_digit_sel and o_segments are both registered from the same next-state, so they are always mutually consistent.
- Decode per nibble:
  - 0..9 → ZERO..NINE.
  - 10 → SIGN.
  - 11..15 → OFF.
- Sign placement:
  - When the captured sign is 1, the leftmost digit (DIGITS-1) shows SIGN, overriding its BCD nibble.
  - Leading-zero suppression then applies only to digits DIGITS-2..1.
- Leading-zero suppression (BLANK_LEADING=1):
  - Digit k is shown as OFF if every digit from k up to the top non-sign digit is 0.
  - Digit 0 is never blanked, so value 0 displays as a single ZERO.
  - Blanked digits still receive their o_digit_sel slot.
- i_enable=0: o_digit_sel=0, o_segments=OFF, slot counter and index are forced back to their reset state. Shadow and o_valid keep their values.
- o_valid=0: the display stays dark and the scan is held, exactly as when i_enable=0.
- Simultaneous events:
  - i_rdy coinciding with a slot boundary: the new value applies from the next slot's outputs onward. A torn digit within one slot is permitted.
  - rst and i_rdy in the same cycle: rst wins and nothing is captured.
  - rst mid-slot: outputs go dark on the next edge and the scan restarts from the reset state.

Test Plan (DIGITS=4, REFRESH_DIV=4, GUARD=1, BLANK_LEADING=1 unless stated):
- Reset, then idle 20 cycles → o_digit_sel=0000, o_segments=OFF, o_valid=0 throughout.
- i_bcd=16'h1234, i_sign=0, i_rdy pulse, i_enable=1.
  - Expect o_valid=1.
  - Repeating 16-cycle pattern of one guard cycle (0000/OFF) then three cycles of each: 1000/ONE, 0100/TWO, 0010/TREE, 0001/FOUR.
- i_bcd=16'h0007, i_sign=0 → selects 1000/0100/0010 show OFF; 0001 shows SEVEN. Load 16'h0000 → only 0001 shows ZERO.
- i_bcd=16'h0042, i_sign=1 → 1000 shows SIGN, 0100 shows OFF, 0010 FOUR, 0001 TWO. Repeat with BLANK_LEADING=0 → 0100 shows ZERO.
- i_bcd=16'h9ABF → 1000 NINE, 0100 SIGN, 0010 OFF, 0001 OFF.
- Mid-scan cases:
  - Deassert i_enable mid-scan → dark on the next edge. Reassert → scan restarts at digit 3, beginning with a guard cycle; shadow value is retained.
  - Assert rst mid-slot → all outputs at reset values on the next edge; a subsequent reload is required to display.
